// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multicycle sequencer and the MIPS datapath.
// The sequencer owns every enable; the datapath returns opcode and the ALU zero flag.
interface multicycle_control_unit_if;
    logic [5:0]  opcode;
    logic        zero;
    logic        pc_write;
    logic        ir_write;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_dst;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [3:0]  alu_op;
    logic [1:0]  pc_source;
    logic        illegal;
    logic [3:0]  state;
    logic [31:0] instr_count;

    modport master (
        input  opcode, zero,
        output pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
               illegal, state, instr_count
    );

    modport slave (
        output opcode, zero,
        input  pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
               illegal, state, instr_count
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS main sequencer: fetch/decode/execute/memory/write-back FSM with
// memory states stretched to MEM_LAT cycles and a retired-instruction counter.
module multicycle_control_unit #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    multicycle_control_unit_if.master    bus
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] LAST_WAIT = 4'(MEM_LAT - 1);

    state_t      state_r;
    state_t      next_state_s;
    logic [3:0]  wait_r;
    logic [3:0]  wait_next_s;
    logic [5:0]  op_r;
    logic        rtype_r;
    logic [31:0] cnt_r;
    logic        retire_s;
    logic        mem_state_s;
    logic        last_s;

    assign mem_state_s = (state_r == S_FETCH) || (state_r == S_MEM_READ) ||
                         (state_r == S_MEM_WRITE);
    assign last_s      = (wait_r == LAST_WAIT);

    // State, wait counter, latched opcode and retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_FETCH;
            wait_r  <= 4'd0;
            op_r    <= 6'd0;
            rtype_r <= 1'b0;
            cnt_r   <= 32'd0;
        end else begin
            state_r <= next_state_s;
            wait_r  <= wait_next_s;
            // Opcode is only trusted in DECODE; later states use the latched copy
            if (state_r == S_DECODE) begin
                op_r    <= bus.opcode;
                rtype_r <= (bus.opcode == OP_RTYPE);
            end
            if (retire_s) begin
                cnt_r <= cnt_r + 32'd1;
            end
        end
    end

    // Next-state, wait-counter advance and retire detection
    always_comb begin
        next_state_s = S_FETCH;
        retire_s     = 1'b0;
        wait_next_s  = 4'd0;
        if (mem_state_s && !last_s) begin
            wait_next_s = wait_r + 4'd1;
        end else begin
            wait_next_s = 4'd0;
        end
        case (state_r)
            S_FETCH:     next_state_s = last_s ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:              next_state_s = S_EXEC_R;
                    OP_LW, OP_SW:          next_state_s = S_MEM_ADDR;
                    OP_ADDI, OP_ANDI,
                    OP_ORI:                next_state_s = S_EXEC_I;
                    OP_BEQ:                next_state_s = S_BRANCH;
                    OP_J:                  next_state_s = S_JUMP;
                    default:               next_state_s = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  next_state_s = (op_r == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  next_state_s = last_s ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB: begin
                next_state_s = S_FETCH;
                retire_s     = 1'b1;
            end
            S_MEM_WRITE: begin
                next_state_s = last_s ? S_FETCH : S_MEM_WRITE;
                retire_s     = last_s;
            end
            S_EXEC_R:    next_state_s = S_ALU_WB;
            S_EXEC_I:    next_state_s = S_ALU_WB;
            S_ALU_WB, S_BRANCH, S_JUMP: begin
                next_state_s = S_FETCH;
                retire_s     = 1'b1;
            end
            default:     next_state_s = S_FETCH;
        endcase
    end

    // Moore control decode; everything is held at zero while rst is high
    always_comb begin
        bus.pc_write   = 1'b0;
        bus.ir_write   = 1'b0;
        bus.i_or_d     = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.reg_write  = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'd0;
        bus.alu_op     = 4'd0;
        bus.pc_source  = 2'd0;
        bus.illegal    = 1'b0;
        if (rst) begin
            bus.pc_write = 1'b0;
        end else begin
            case (state_r)
                S_FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = 2'd1;
                    bus.ir_write  = last_s;
                    bus.pc_write  = last_s;
                end
                S_DECODE: begin
                    bus.alu_src_b = 2'd3;
                    case (bus.opcode)
                        OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_ORI,
                        OP_BEQ, OP_J: bus.illegal = 1'b0;
                        default:      bus.illegal = 1'b1;
                    endcase
                end
                S_MEM_ADDR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'd2;
                end
                S_MEM_READ: begin
                    bus.mem_read = 1'b1;
                    bus.i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                end
                S_MEM_WRITE: begin
                    bus.mem_write = 1'b1;
                    bus.i_or_d    = 1'b1;
                end
                S_EXEC_R: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = 4'd6;
                end
                S_EXEC_I: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'd2;
                    case (op_r)
                        OP_ANDI: bus.alu_op = 4'd4;
                        OP_ORI:  bus.alu_op = 4'd5;
                        default: bus.alu_op = 4'd2;
                    endcase
                end
                S_ALU_WB: begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = rtype_r;
                end
                S_BRANCH: begin
                    // Branch resolves in this very cycle from the live zero flag
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = 4'd1;
                    bus.pc_source = 2'd1;
                    bus.pc_write  = bus.zero;
                end
                S_JUMP: begin
                    bus.pc_source = 2'd2;
                    bus.pc_write  = 1'b1;
                end
                default: bus.pc_write = 1'b0;
            endcase
        end
    end

    assign bus.state       = state_r;
    assign bus.instr_count = cnt_r;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit at MEM_LAT=1 and MEM_LAT=3, checked
// cycle by cycle against a per-instruction phase-list model.
module tb_multicycle_control_unit;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEM_ADDR = 2, S_MEM_READ = 3,
                   S_MEM_WB = 4, S_MEM_WRITE = 5, S_EXEC_R = 6, S_EXEC_I = 7,
                   S_ALU_WB = 8, S_BRANCH = 9, S_JUMP = 10;
    localparam int K_R = 0, K_LW = 1, K_SW = 2, K_I = 3, K_BEQ = 4, K_J = 5, K_ILL = 6;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
        logic [3:0] state;
    } obs_t;

    logic clk;
    logic rst0;
    logic rst1;
    int   checks;
    int   failures;
    logic [31:0] mcnt;
    obs_t obs0;
    obs_t obs1;

    multicycle_control_unit_if if0 ();
    multicycle_control_unit_if if1 ();

    multicycle_control_unit #(.MEM_LAT(1)) dut0 (.clk(clk), .rst(rst0), .bus(if0.master));
    multicycle_control_unit #(.MEM_LAT(3)) dut1 (.clk(clk), .rst(rst1), .bus(if1.master));

    always #5 clk = ~clk;

    assign obs0 = {if0.pc_write, if0.ir_write, if0.i_or_d, if0.mem_read, if0.mem_write,
                   if0.mem_to_reg, if0.reg_dst, if0.reg_write, if0.alu_src_a,
                   if0.alu_src_b, if0.alu_op, if0.pc_source, if0.illegal, if0.state};
    assign obs1 = {if1.pc_write, if1.ir_write, if1.i_or_d, if1.mem_read, if1.mem_write,
                   if1.mem_to_reg, if1.reg_dst, if1.reg_write, if1.alu_src_a,
                   if1.alu_src_b, if1.alu_op, if1.pc_source, if1.illegal, if1.state};

    function automatic obs_t observed(input bit sel);
        return sel ? obs1 : obs0;
    endfunction

    function automatic logic [31:0] count_of(input bit sel);
        return sel ? if1.instr_count : if0.instr_count;
    endfunction

    function automatic int op_kind(input logic [5:0] op);
        case (op)
            6'b000000: return K_R;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b001000, 6'b001100, 6'b001101: return K_I;
            6'b000100: return K_BEQ;
            6'b000010: return K_J;
            default:   return K_ILL;
        endcase
    endfunction

    function automatic obs_t state_only(input int ph);
        obs_t e;
        e = '0;
        e.state = 4'(ph);
        return e;
    endfunction

    // Expected control word for one cycle of a given phase
    function automatic obs_t exp_out(input int ph, input logic [5:0] op, input logic z,
                                     input bit last);
        obs_t e;
        e = state_only(ph);
        case (ph)
            S_FETCH:     begin e.mem_read = 1'b1; e.alu_src_b = 2'd1;
                               e.ir_write = last; e.pc_write = last; end
            S_DECODE:    begin e.alu_src_b = 2'd3; e.illegal = (op_kind(op) == K_ILL); end
            S_MEM_ADDR:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; end
            S_MEM_READ:  begin e.mem_read = 1'b1; e.i_or_d = 1'b1; end
            S_MEM_WB:    begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; end
            S_MEM_WRITE: begin e.mem_write = 1'b1; e.i_or_d = 1'b1; end
            S_EXEC_R:    begin e.alu_src_a = 1'b1; e.alu_op = 4'd6; end
            S_EXEC_I:    begin e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
                               e.alu_op = (op == 6'b001000) ? 4'd2 :
                                          (op == 6'b001100) ? 4'd4 : 4'd5; end
            S_ALU_WB:    begin e.reg_write = 1'b1; e.reg_dst = (op == 6'b000000); end
            S_BRANCH:    begin e.alu_src_a = 1'b1; e.alu_op = 4'd1; e.pc_source = 2'd1;
                               e.pc_write = z; end
            S_JUMP:      begin e.pc_source = 2'd2; e.pc_write = 1'b1; end
            default:     e.state = 4'(ph);
        endcase
        return e;
    endfunction

    task automatic check_obs(input string tag, input obs_t o, input obs_t e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic check_cnt(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    task automatic drive(input bit sel, input logic [5:0] op, input logic z);
        if (sel) begin if1.opcode = op; if1.zero = z; end
        else     begin if0.opcode = op; if0.zero = z; end
    endtask

    task automatic set_rst(input bit sel, input logic v);
        if (sel) rst1 = v; else rst0 = v;
    endtask

    task automatic do_reset(input bit sel, input int ncyc);
        set_rst(sel, 1'b1);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
            drive(sel, 6'($urandom), 1'($urandom));
            @(negedge clk);
            check_obs($sformatf("reset_%0d_c%0d", sel, i), observed(sel), state_only(S_FETCH));
            check_cnt($sformatf("reset_cnt_%0d", sel), count_of(sel), 32'd0);
        end
        @(posedge clk); #1;
        set_rst(sel, 1'b0);
        mcnt = 32'd0;
    endtask

    // Entered one step after a posedge with the DUT in its first FETCH cycle
    task automatic run_instr(input bit sel, input int lat, input logic [5:0] op,
                             input int zf, input int abort_idx);
        int ph_q[$];
        int kind;
        bit last;
        logic z;
        obs_t e;
        kind = op_kind(op);
        for (int i = 0; i < lat; i++) ph_q.push_back(S_FETCH);
        ph_q.push_back(S_DECODE);
        case (kind)
            K_R:   begin ph_q.push_back(S_EXEC_R); ph_q.push_back(S_ALU_WB); end
            K_LW:  begin ph_q.push_back(S_MEM_ADDR);
                         for (int i = 0; i < lat; i++) ph_q.push_back(S_MEM_READ);
                         ph_q.push_back(S_MEM_WB); end
            K_SW:  begin ph_q.push_back(S_MEM_ADDR);
                         for (int i = 0; i < lat; i++) ph_q.push_back(S_MEM_WRITE); end
            K_I:   begin ph_q.push_back(S_EXEC_I); ph_q.push_back(S_ALU_WB); end
            K_BEQ: ph_q.push_back(S_BRANCH);
            K_J:   ph_q.push_back(S_JUMP);
            default: ;
        endcase
        for (int k = 0; k < ph_q.size(); k++) begin
            z = (zf < 0) ? 1'($urandom) : 1'(zf);
            drive(sel, (ph_q[k] == S_DECODE) ? op : 6'($urandom), z);
            if (k == abort_idx) set_rst(sel, 1'b1);
            @(negedge clk);
            last = (k + 1 == ph_q.size()) || (ph_q[k + 1] != ph_q[k]);
            e = (k == abort_idx) ? state_only(ph_q[k]) : exp_out(ph_q[k], op, z, last);
            check_obs($sformatf("L%0d_op%02h_c%0d", lat, op, k), observed(sel), e);
            check_cnt($sformatf("cnt_L%0d_op%02h_c%0d", lat, op, k), count_of(sel), mcnt);
            @(posedge clk); #1;
            if (k == abort_idx) begin
                set_rst(sel, 1'b0);
                mcnt = 32'd0;
                return;
            end
        end
        if (kind != K_ILL) mcnt = mcnt + 32'd1;
    endtask

    task automatic run_random(input bit sel, input int lat, input int n);
        logic [5:0] tbl [8];
        logic [5:0] op;
        int pick;
        tbl = '{6'b000000, 6'b100011, 6'b101011, 6'b001000,
                6'b001100, 6'b001101, 6'b000100, 6'b000010};
        for (int i = 0; i < n; i++) begin
            pick = int'($urandom_range(0, 9));
            op = (pick >= 8) ? 6'($urandom) : tbl[pick];
            run_instr(sel, lat, op, -1, -1);
        end
    endtask

    initial begin
        clk = 1'b0;
        rst0 = 1'b1;
        rst1 = 1'b1;
        checks = 0;
        failures = 0;
        mcnt = 32'd0;
        drive(1'b0, 6'd0, 1'b0);
        drive(1'b1, 6'd0, 1'b0);

        do_reset(1'b0, 2);
        run_instr(1'b0, 1, 6'b000000, -1, -1);
        run_instr(1'b0, 1, 6'b001000, -1, -1);
        run_instr(1'b0, 1, 6'b001100, -1, -1);
        run_instr(1'b0, 1, 6'b001101, -1, -1);
        run_instr(1'b0, 1, 6'b000010, -1, -1);
        run_instr(1'b0, 1, 6'b000100, 1, -1);
        run_instr(1'b0, 1, 6'b000100, 0, -1);
        run_instr(1'b0, 1, 6'b111111, -1, -1);
        run_instr(1'b0, 1, 6'b100011, -1, -1);
        run_instr(1'b0, 1, 6'b101011, -1, -1);
        run_random(1'b0, 1, 25);

        rst0 = 1'b1;
        do_reset(1'b1, 2);
        run_instr(1'b1, 3, 6'b100011, -1, -1);
        run_instr(1'b1, 3, 6'b101011, -1, -1);
        run_random(1'b1, 3, 15);
        run_instr(1'b1, 3, 6'b101011, -1, 5);
        run_instr(1'b1, 3, 6'b000000, -1, -1);
        run_instr(1'b1, 3, 6'b000100, 1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Main sequencer for the multicycle MIPS datapath. Steps each instruction through fetch, decode, execute, memory and write-back states.
- Drives the register-file, memory, mux and PC enables, and the 4-bit alu_op consumed by the ALU control unit.
- Stretches memory states for a parameterised synchronous memory latency.
- Counts retired instructions.

Parameters:
- MEM_LAT, 1, cycles each memory access state is held (1..15).

Ports:
- clk  in  1  system clock, all state changes on posedge
- rst  in  1  synchronous active-high reset
- opcode  in  6  instr[31:26] from instruction register
- zero  in  1  ALU zero flag
- pc_write  out  1  PC load enable
- ir_write  out  1  instruction register load enable
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALU out
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_to_reg  out  1  write-back select: 1 = memory data
- reg_dst  out  1  write register select: 1 = rd, 0 = rt
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = rs data
- alu_src_b  out  2  0 = rt data, 1 = const 4, 2 = sign-extended imm, 3 = imm << 2
- alu_op  out  4  0 add, 1 sub, 2 add, 4 and, 5 or, 6 = use func field
- pc_source  out  2  0 = ALU result, 1 = ALU out register, 2 = jump target
- illegal  out  1  one-cycle pulse on unsupported opcode
- state  out  4  current state encoding, for debug
- instr_count  out  32  retired instruction count

Behaviour:
- Reset: while rst=1, state<=FETCH, wait counter<=0, instr_count<=0. All control outputs are forced to 0 that cycle, including pc_write, mem_read and illegal.
- Reset mid-instruction aborts the instruction. No write strobe is asserted in the reset cycle. The instruction is not counted.
- State encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, EXEC_I 7, ALU_WB 8, BRANCH 9, JUMP 10.
- Outputs are Moore, decoded from state, except pc_write in BRANCH.
- Any output not listed for a state is 0.
- Memory states FETCH, MEM_READ and MEM_WRITE:
  - Each holds for exactly MEM_LAT cycles, using an internal counter.
  - The counter clears on exit.
  - The strobe (mem_read or mem_write) is asserted on every cycle of the state.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0. ir_write=1 and pc_write=1 on the last cycle only. Next state: DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=0 (branch target precompute).
- DECODE next state by opcode:
  - 000000 (R-type) -> EXEC_R
  - 100011 (lw) or 101011 (sw) -> MEM_ADDR
  - 001000 (addi), 001100 (andi), 001101 (ori) -> EXEC_I
  - 000100 (beq) -> BRANCH
  - 000010 (j) -> JUMP
  - other opcodes -> FETCH, with illegal=1 for that DECODE cycle. The instruction is not counted.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=0. Next: MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: i_or_d=1. Next: MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next: FETCH.
- MEM_WRITE: i_or_d=1. Next: FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=6. Next: ALU_WB.
- EXEC_I: alu_src_a=1, alu_src_b=2. alu_op=2 for addi, 4 for andi, 5 for ori. Next: ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0. reg_dst=1 if the instruction came from EXEC_R, else 0 (tracked by an internal flag). Next: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_source=1. pc_write = zero, combinationally in the same cycle. Next: FETCH.
- JUMP: pc_source=2, pc_write=1. Next: FETCH.
- Opcode is sampled only in DECODE; changes on opcode in other states are ignored.
- instr_count increments by 1 on every transition into FETCH from MEM_WB, MEM_WRITE, ALU_WB, BRANCH or JUMP. Wraps 0xFFFFFFFF -> 0.
- Instruction latency in cycles:
  - R-type and I-type ALU: MEM_LAT+3
  - lw: 2*MEM_LAT+3
  - sw: 2*MEM_LAT+2
  - beq and j: MEM_LAT+2

Test Plan:
- Reset: MEM_LAT=1, rst high 2 cycles then low -> state=0, instr_count=0, all strobes 0 during reset. FETCH begins the cycle after rst falls; pc_write=1 and ir_write=1 in that cycle.
- R-type: MEM_LAT=1, opcode=000000 -> state sequence 0,1,6,8,0. alu_op=6 in EXEC_R. reg_write=1 with reg_dst=1 in ALU_WB. instr_count=1 after 4 cycles.
- lw/sw with MEM_LAT=3: lw -> FETCH 3 cycles, MEM_READ 3 cycles with mem_read=1 and i_or_d=1; total 9 cycles. sw -> mem_write=1 for 3 cycles, never reg_write; total 8 cycles.
- beq: zero=1 -> pc_write=1 in BRANCH with pc_source=1. zero=0 -> pc_write=0. Both paths take 3 cycles at MEM_LAT=1; alu_op=1.
- addi/andi/ori/j/illegal: alu_op=2/4/5 in EXEC_I with reg_dst=0. j gives pc_source=2, pc_write=1. Opcode 111111 gives an illegal pulse of exactly 1 cycle, return to FETCH, instr_count unchanged.
- Abort: rst asserted in the MEM_WRITE cycle of sw -> mem_write=0 that cycle, state=FETCH next, instr_count=0.
